regfile_2w2r: RTL and testbench

//   Parametrised register file for the 16-bit processor datapath: two combinational read

---
 rtl/regfile_2w2r.sv | 100 ++++++++++
 tb/tb_regfile_2w2r.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2w2r.sv
// regfile_2w2r: register file with two write ports and two combinational read ports.
//   Port A is ALU writeback and port B is load writeback. When both ports write the
//   same address on one edge, port B's data is stored.
//   Optional behaviour, selected by parameters:
//     ZERO_REG - R0 is hardwired to zero.
//     BYPASS   - a read returns data being written in the same cycle.
// Ports:
//   clk, reset           clock (writes on rising edge); async active-high clear
//   we_a, wa_a, wd_a     write port A: enable, address, data
//   we_b, wa_b, wd_b     write port B: enable, address, data (wins on collision)
//   ra1/rd1, ra2/rd2     read ports: address in, combinational data out

// One read port: stored value, optional same-cycle bypass, optional zero register.
module regfile_rdport #(
   parameter int WIDTH    = 16,
   parameter int REGBITS  = 4,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic [2**REGBITS-1:0][WIDTH-1:0] mem,
   input  logic                             reset,
   input  logic                             we_a,
   input  logic [REGBITS-1:0]               wa_a,
   input  logic [WIDTH-1:0]                 wd_a,
   input  logic                             we_b,
   input  logic [REGBITS-1:0]               wa_b,
   input  logic [WIDTH-1:0]                 wd_b,
   input  logic [REGBITS-1:0]               ra,
   output logic [WIDTH-1:0]                 rd
);
   always_comb begin
      rd = mem[ra];
      // Bypass is suppressed under reset, so every address reads 0.
      // Port B is checked first because it also wins a write collision.
      if (BYPASS != 0 && !reset) begin
         if (we_b && wa_b == ra)      rd = wd_b;
         else if (we_a && wa_a == ra) rd = wd_a;
      end
      // The zero register also overrides the bypass.
      if (ZERO_REG != 0 && ra == '0) rd = '0;
   end
endmodule

module regfile_2w2r #(
   parameter int WIDTH    = 16,
   parameter int REGBITS  = 4,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we_a,
   input  logic [REGBITS-1:0] wa_a,
   input  logic [WIDTH-1:0]   wd_a,
   input  logic               we_b,
   input  logic [REGBITS-1:0] wa_b,
   input  logic [WIDTH-1:0]   wd_b,
   input  logic [REGBITS-1:0] ra1,
   input  logic [REGBITS-1:0] ra2,
   output logic [WIDTH-1:0]   rd1,
   output logic [WIDTH-1:0]   rd2
);
   localparam int DEPTH  = 2**REGBITS;
   localparam int NUM_RD = 2;

   logic [DEPTH-1:0][WIDTH-1:0]    mem;
   logic [NUM_RD-1:0][REGBITS-1:0] ra_v;
   logic [NUM_RD-1:0][WIDTH-1:0]   rd_v;
   logic                           wen_a, wen_b;

   // Writes to R0 are dropped when it is hardwired.
   assign wen_a = we_a && !(ZERO_REG != 0 && wa_a == '0);
   assign wen_b = we_b && !(ZERO_REG != 0 && wa_b == '0);

   // Port B is written last, so its data wins when both ports hit one address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem <= '0;
      end else begin
         if (wen_a) mem[wa_a] <= wd_a;
         if (wen_b) mem[wa_b] <= wd_b;
      end
   end

   assign ra_v = {ra2, ra1};

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      regfile_rdport #(
         .WIDTH(WIDTH), .REGBITS(REGBITS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
      ) u_rd (
         .mem(mem), .reset(reset),
         .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
         .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
         .ra(ra_v[g]), .rd(rd_v[g])
      );
   end

   assign rd1 = rd_v[0];
   assign rd2 = rd_v[1];
endmodule

// File: tb/tb_regfile_2w2r.sv
// Testbench for regfile_2w2r. It runs three builds side by side:
//   d0 = defaults (16/4, zero reg, bypass)
//   d1 = 16/4, no zero reg, no bypass
//   d2 = 32/5, zero reg, bypass
module tb_regfile_2w2r;
   logic clk = 1'b0;
   logic reset;
   logic        we_a [3], we_b [3];
   logic [4:0]  wa_a [3], wa_b [3], ra1 [3], ra2 [3];
   logic [31:0] wd_a [3], wd_b [3];
   logic [15:0] r1_0, r2_0, r1_1, r2_1;
   logic [31:0] r1_2, r2_2;
   logic [31:0] mdl [3][32];
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   regfile_2w2r #(.WIDTH(16), .REGBITS(4), .ZERO_REG(1), .BYPASS(1)) u0 (
      .clk(clk), .reset(reset),
      .we_a(we_a[0]), .wa_a(wa_a[0][3:0]), .wd_a(wd_a[0][15:0]),
      .we_b(we_b[0]), .wa_b(wa_b[0][3:0]), .wd_b(wd_b[0][15:0]),
      .ra1(ra1[0][3:0]), .ra2(ra2[0][3:0]), .rd1(r1_0), .rd2(r2_0));
   regfile_2w2r #(.WIDTH(16), .REGBITS(4), .ZERO_REG(0), .BYPASS(0)) u1 (
      .clk(clk), .reset(reset),
      .we_a(we_a[1]), .wa_a(wa_a[1][3:0]), .wd_a(wd_a[1][15:0]),
      .we_b(we_b[1]), .wa_b(wa_b[1][3:0]), .wd_b(wd_b[1][15:0]),
      .ra1(ra1[1][3:0]), .ra2(ra2[1][3:0]), .rd1(r1_1), .rd2(r2_1));
   regfile_2w2r #(.WIDTH(32), .REGBITS(5), .ZERO_REG(1), .BYPASS(1)) u2 (
      .clk(clk), .reset(reset),
      .we_a(we_a[2]), .wa_a(wa_a[2]), .wd_a(wd_a[2]),
      .we_b(we_b[2]), .wa_b(wa_b[2]), .wd_b(wd_b[2]),
      .ra1(ra1[2]), .ra2(ra2[2]), .rd1(r1_2), .rd2(r2_2));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] rd_got(int d, int p);
      case (d)
         0:       return (p == 1) ? {16'h0, r1_0} : {16'h0, r2_0};
         1:       return (p == 1) ? {16'h0, r1_1} : {16'h0, r2_1};
         default: return (p == 1) ? r1_2 : r2_2;
      endcase
   endfunction

   // Expected read value, taken from the read rules of the specification.
   function automatic logic [31:0] exp_rd(int d, logic [4:0] ra);
      bit zr = (d != 1);
      bit bp = (d != 1);
      if (reset) return 32'h0;
      if (zr && ra == 5'd0) return 32'h0;
      if (bp && we_b[d] && wa_b[d] == ra) return wd_b[d];
      if (bp && we_a[d] && wa_a[d] == ra) return wd_a[d];
      return mdl[d][ra];
   endfunction

   // Apply one clock edge to the model.
   function automatic void upd(int d);
      bit zr = (d != 1);
      if (reset) return;
      if (we_b[d] && !(zr && wa_b[d] == 5'd0)) mdl[d][wa_b[d]] = wd_b[d];
      if (we_a[d] && !(zr && wa_a[d] == 5'd0) && !(we_b[d] && wa_b[d] == wa_a[d]))
         mdl[d][wa_a[d]] = wd_a[d];
   endfunction

   function automatic void clear_mdl();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 32; i++) mdl[d][i] = 32'h0;
   endfunction

   task automatic check_all();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d rd1[%0d]", d, ra1[d]), rd_got(d, 1), exp_rd(d, ra1[d]));
         chk($sformatf("d%0d rd2[%0d]", d, ra2[d]), rd_got(d, 2), exp_rd(d, ra2[d]));
      end
   endtask

   // Check the reads before the edge, then take the edge and update the model.
   task automatic step();
      #1 check_all();
      @(posedge clk);
      for (int d = 0; d < 3; d++) upd(d);
      #1;
   endtask

   task automatic idle();
      for (int d = 0; d < 3; d++) begin
         we_a[d] = 1'b0;
         we_b[d] = 1'b0;
      end
   endtask

   task automatic set_w(input int d, input logic wea, input logic [4:0] waa, input logic [31:0] wda,
                        input logic web, input logic [4:0] wab, input logic [31:0] wdb);
      we_a[d] = wea; wa_a[d] = waa; wd_a[d] = wda;
      we_b[d] = web; wa_b[d] = wab; wd_b[d] = wdb;
   endtask

   task automatic set_r(input int d, input logic [4:0] a1, input logic [4:0] a2);
      ra1[d] = a1; ra2[d] = a2;
   endtask

   initial begin
      reset = 1'b1;
      clear_mdl();
      for (int d = 0; d < 3; d++) begin
         set_w(d, 0, 0, 0, 0, 0, 0);
         set_r(d, 5'd3, 5'd9);
      end
      #1 check_all();
      @(negedge clk) reset = 1'b0;
      @(posedge clk) #1;

      // Fill R1..R15 through port A and read each one back.
      for (int i = 1; i < 16; i++) begin
         for (int d = 0; d < 2; d++) begin
            set_w(d, 1, 5'(i), 32'h0100 + i, 0, 0, 0);
            set_r(d, 5'(i), 5'(15 - i));
         end
         step();
      end
      idle();
      for (int i = 0; i < 16; i++) begin
         for (int d = 0; d < 2; d++) set_r(d, 5'(i), 5'(15 - i));
         step();
      end

      // Two writes on one edge, then a collision on R7.
      for (int d = 0; d < 2; d++) begin
         set_w(d, 1, 5'd3, 32'hAAAA, 1, 5'd5, 32'h5555);
         set_r(d, 5'd3, 5'd5);
      end
      step(); idle(); step();
      for (int d = 0; d < 2; d++) begin
         set_w(d, 1, 5'd7, 32'h1111, 1, 5'd7, 32'h2222);
         set_r(d, 5'd7, 5'd7);
      end
      step(); idle(); step();

      // Bypass: R4 is read in the same cycle as its write.
      for (int d = 0; d < 2; d++) begin
         set_w(d, 1, 5'd4, 32'hBEEF, 0, 0, 0);
         set_r(d, 5'd4, 5'd3);
      end
      step(); idle(); step();

      // Zero register: both ports write R0.
      for (int d = 0; d < 2; d++) begin
         set_w(d, 1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hFFFF);
         set_r(d, 5'd0, 5'd0);
      end
      step(); idle(); step();

      // Async reset between edges; writes are ignored while it is held.
      for (int d = 0; d < 3; d++) begin
         set_w(d, 1, 5'd9, 32'h1234, 0, 0, 0);
         set_r(d, 5'd9, 5'd4);
      end
      step(); idle(); step();
      #2 reset = 1'b1;
      clear_mdl();
      #1 check_all();
      for (int d = 0; d < 3; d++) set_w(d, 1, 5'd9, 32'h7777, 0, 0, 0);
      step(); step();
      #2 reset = 1'b0;
      step(); idle(); step();

      // Wide build: R31 and R16 check the top address bit and full data width.
      set_w(2, 1, 5'd31, 32'hDEADBEEF, 1, 5'd16, 32'hCAFEF00D);
      set_r(2, 5'd31, 5'd16);
      step(); idle(); step();
      set_r(2, 5'd15, 5'd31);
      step();

      // Random traffic, with an occasional async reset pulse.
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 3; d++) begin
            logic [4:0]  am;
            logic [31:0] dm;
            am = (d == 2) ? 5'h1F : 5'h0F;
            dm = (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            set_w(d, 1'($urandom), 5'($urandom) & am, $urandom & dm,
                  1'($urandom), 5'($urandom) & am, $urandom & dm);
            if ($urandom_range(3) == 0) wa_b[d] = wa_a[d];
            set_r(d, 5'($urandom) & am, 5'($urandom) & am);
            if ($urandom_range(2) == 0) ra1[d] = wa_a[d];
            if ($urandom_range(2) == 0) ra2[d] = wa_b[d];
         end
         if (n % 97 == 50) begin
            reset = 1'b1;
            clear_mdl();
            step();
            reset = 1'b0;
         end else begin
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
